// File: rtl/led_run_pkg.sv
// ---------------------------------------------------------------------------
// led_run_pkg
// Shared types and constants for the LED running-light controller.
//   run_state_e      : controller FSM encoding (IDLE / RUN / HOLD)
//   N_LED_DEFAULT    : default number of LED outputs
//   STEP_DIV_DEFAULT : default number of tick rises per pattern step
//   DIV_CNT_W        : width of the tick divider counter
// ---------------------------------------------------------------------------
package led_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } run_state_e;

    localparam int N_LED_DEFAULT    = 4;
    localparam int STEP_DIV_DEFAULT = 1;
    localparam int DIV_CNT_W        = 8;

endpackage

// File: rtl/led_tick_div.sv
// ---------------------------------------------------------------------------
// led_tick_div
// Rising-edge detector on the upstream LED pulse plus a STEP_DIV divider.
// step_o is combinational so the controller can move the pattern on the same
// clock edge at which the qualifying tick rise is first sampled.
// Ports:
//   clk_i   : system clock
//   rst_i   : asynchronous reset, active-high
//   tick_i  : upstream pulse/level; only low-to-high transitions count
//   en_i    : rises are counted only while high (controller in RUN, no Stop)
//   clr_i   : synchronous clear of the divider count
//   step_o  : high for the cycle in which a pattern step must be taken
// ---------------------------------------------------------------------------
module led_tick_div
    import led_run_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic en_i,
    input  logic clr_i,
    output logic step_o
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(STEP_DIV - 1);

    logic                 tick_q;   // tick_i delayed by one clock
    logic [DIV_CNT_W-1:0] cnt_q;
    logic [DIV_CNT_W-1:0] cnt_d;
    logic                 rise;

    // tick_q clears in reset, so a tick already high at reset release reads
    // as a rise on the first edge; it is harmless because the controller is
    // in IDLE there and en_i is low.
    assign rise   = tick_i & ~tick_q;
    assign step_o = en_i & rise & (cnt_q == DIV_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && rise) begin
            cnt_d = (cnt_q == DIV_LAST) ? '0 : cnt_q + DIV_CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            tick_q <= tick_i;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/led_run_ctrl.sv
// ---------------------------------------------------------------------------
// led_run_ctrl
// Running-light (one-hot rotating) LED driver stepped by the upstream LED
// pulse, with start / stop / hold control, direction select and a wrap flag.
// Ports:
//   CLK        : system clock, all state changes on its rising edge
//   RST        : asynchronous reset, active-high
//   Tick_In    : upstream LED pulse; rising edges advance the divider
//   Start      : start from IDLE, resume from HOLD
//   Stop       : freeze from RUN, clear from HOLD; wins over Start
//   Dir        : 0 = step toward MSB, 1 = step toward LSB
//   LED_Out    : registered one-hot pattern, zero in IDLE
//   Busy       : registered, high in RUN or HOLD
//   Wrap_Pulse : registered, one cycle high after a wrapping step
// Build option:
//   LED_RUN_BOUNCE_EN : pattern bounces between the ends instead of
//                       wrapping; Dir is sampled only when leaving IDLE and
//                       the direction is held internally.
// ---------------------------------------------------------------------------
module led_run_ctrl
    import led_run_pkg::*;
#(
    parameter int N_LED    = N_LED_DEFAULT,
    parameter int STEP_DIV = STEP_DIV_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Tick_In,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Dir,
    output logic [N_LED-1:0] LED_Out,
    output logic             Busy,
    output logic             Wrap_Pulse
);

    run_state_e       state_q;
    run_state_e       state_d;
    logic [N_LED-1:0] led_q;
    logic [N_LED-1:0] led_d;
    logic             busy_q;
    logic             busy_d;
    logic             wrap_q;
    logic             wrap_d;

    logic             step;       // divider says: take a step this edge
    logic             div_en;
    logic             div_clr;
    logic             start_load; // IDLE -> RUN on this edge
    logic [N_LED-1:0] led_load;
    logic [N_LED-1:0] led_step;   // pattern after one step
    logic             step_wrap;  // that step crosses / reverses at an end

    assign start_load = (state_q == IDLE) && Start && !Stop;

    // A rise arriving together with Stop is dropped entirely (no step and no
    // count), so the frozen pattern and divider phase match the pre-Stop view.
    assign div_en  = (state_q == RUN) && !Stop;
    assign div_clr = start_load || ((state_q == HOLD) && Stop);

    assign led_load = Dir ? {1'b1, {(N_LED-1){1'b0}}}
                          : {{(N_LED-1){1'b0}}, 1'b1};

    led_tick_div #(
        .STEP_DIV (STEP_DIV)
    ) u_tick_div (
        .clk_i  (CLK),
        .rst_i  (RST),
        .tick_i (Tick_In),
        .en_i   (div_en),
        .clr_i  (div_clr),
        .step_o (step)
    );

`ifdef LED_RUN_BOUNCE_EN
    logic dir_q;
    logic dir_d;

    // Shift without wrap; reaching an end flips the direction on that same
    // step, so the next step already moves away from the end.
    always_comb begin
        if (dir_q) begin
            led_step  = led_q >> 1;
            step_wrap = led_step[0];
        end else begin
            led_step  = led_q << 1;
            step_wrap = led_step[N_LED-1];
        end

        dir_d = dir_q;
        if (start_load) begin
            dir_d = Dir;
        end else if (step && step_wrap) begin
            dir_d = ~dir_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Plain rotation; Dir is taken live at every step.
    always_comb begin
        if (Dir) begin
            led_step  = {led_q[0], led_q[N_LED-1:1]};
            step_wrap = led_q[0];
        end else begin
            led_step  = {led_q[N_LED-2:0], led_q[N_LED-1]};
            step_wrap = led_q[N_LED-1];
        end
    end
`endif

    // Next-state and output logic. Stop is tested before Start everywhere so
    // that a simultaneous request always resolves in favour of Stop.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d = RUN;
                    led_d   = led_load;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (Stop) begin
                    state_d = HOLD;
                end else if (step) begin
                    led_d  = led_step;
                    wrap_d = step_wrap;
                end
            end
            HOLD: begin
                if (Stop) begin
                    state_d = IDLE;
                    led_d   = '0;
                    busy_d  = 1'b0;
                end else if (Start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                led_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            led_q   <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign LED_Out    = led_q;
    assign Busy       = busy_q;
    assign Wrap_Pulse = wrap_q;

endmodule

// File: tb/tb_led_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_run_ctrl
// Self-checking bench for led_run_ctrl. Two instances share the stimulus:
// u_dut1 (STEP_DIV = 1) and u_dut3 (STEP_DIV = 3); each expectation names
// the instance it applies to. Expected outputs are queued when the stimulus
// for a clock edge is driven and popped/compared once that edge has passed.
// Build option: LED_RUN_BOUNCE_EN selects the bounce expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_run_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Tick_In;
    logic       Start;
    logic       Stop;
    logic       Dir;
    logic [3:0] led1;
    logic [3:0] led3;
    logic       busy1;
    logic       busy3;
    logic       wrap1;
    logic       wrap3;

    always #5 CLK = ~CLK;

    led_run_ctrl #(.N_LED(4), .STEP_DIV(1)) u_dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .Tick_In    (Tick_In),
        .Start      (Start),
        .Stop       (Stop),
        .Dir        (Dir),
        .LED_Out    (led1),
        .Busy       (busy1),
        .Wrap_Pulse (wrap1)
    );

    led_run_ctrl #(.N_LED(4), .STEP_DIV(3)) u_dut3 (
        .CLK        (CLK),
        .RST        (RST),
        .Tick_In    (Tick_In),
        .Start      (Start),
        .Stop       (Stop),
        .Dir        (Dir),
        .LED_Out    (led3),
        .Busy       (busy3),
        .Wrap_Pulse (wrap3)
    );

    // Wrap expected when the pattern moves 0100 -> 1000 (only a bounce at top).
`ifdef LED_RUN_BOUNCE_EN
    localparam logic WRAP_TOP = 1'b1;
`else
    localparam logic WRAP_TOP = 1'b0;
`endif

    typedef struct {
        string      tag;
        bit         sel3;
        logic [3:0] led;
        logic       busy;
        logic       wrap;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         sel3   = 1'b0;   // which instance expectations refer to
    logic [3:0] exp_led;         // pattern expected to persist between steps
    logic       exp_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] led,
                              input logic busy, input logic wrap);
        exp_t e;
        e.tag  = tag;
        e.sel3 = sel3;
        e.led  = led;
        e.busy = busy;
        e.wrap = wrap;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".led"},  32'(e.sel3 ? led3  : led1),  32'(e.led));
            check({e.tag, ".busy"}, 32'(e.sel3 ? busy3 : busy1), 32'(e.busy));
            check({e.tag, ".wrap"}, 32'(e.sel3 ? wrap3 : wrap1), 32'(e.wrap));
        end
    endtask

    // One clock: drive, pass the edge, compare whatever was queued for it.
    task automatic cyc(input bit start, input bit stop, input bit tick);
        Start   = start;
        Stop    = stop;
        Tick_In = tick;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        Stop  = 1'b0;
        drain();
    endtask

    // Tick low for a cycle (pattern steady, wrap low), then high (rise).
    task automatic rise(input string tag, input logic [3:0] led_after,
                        input logic wrap, input bit stop);
        expect_out({tag, ".lo"}, exp_led, exp_busy, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        exp_led = led_after;
        expect_out(tag, exp_led, exp_busy, wrap);
        cyc(1'b0, stop, 1'b1);
    endtask

    task automatic do_reset(input string tag, input bit tick_level);
        Tick_In = tick_level;
        Start   = 1'b0;
        Stop    = 1'b0;
        RST     = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        exp_led  = 4'b0000;
        exp_busy = 1'b0;
        expect_out(tag, 4'b0000, 1'b0, 1'b0);
        drain();
    endtask

    task automatic start_run(input string tag, input logic [3:0] led_load);
        exp_led  = led_load;
        exp_busy = 1'b1;
        expect_out(tag, exp_led, exp_busy, 1'b0);
        cyc(1'b1, 1'b0, Tick_In);
    endtask

    initial begin
        RST     = 1'b1;
        Tick_In = 1'b0;
        Start   = 1'b0;
        Stop    = 1'b0;
        Dir     = 1'b0;

        // Basic run from bit0 toward MSB, wrap (or bounce) behaviour.
        sel3 = 1'b0;
        do_reset("t1.rst", 1'b0);
        Dir = 1'b0;
        start_run("t1.start", 4'b0001);
`ifdef LED_RUN_BOUNCE_EN
        rise("t1.r1", 4'b0010, 1'b0, 1'b0);
        rise("t1.r2", 4'b0100, 1'b0, 1'b0);
        rise("t1.r3", 4'b1000, 1'b1, 1'b0);
        Dir = 1'b1;   // ignored while running in bounce mode
        rise("t1.r4", 4'b0100, 1'b0, 1'b0);
        rise("t1.r5", 4'b0010, 1'b0, 1'b0);
        rise("t1.r6", 4'b0001, 1'b1, 1'b0);
        rise("t1.r7", 4'b0010, 1'b0, 1'b0);
        Dir = 1'b0;
`else
        rise("t1.r1", 4'b0010, 1'b0, 1'b0);
        rise("t1.r2", 4'b0100, 1'b0, 1'b0);
        rise("t1.r3", 4'b1000, 1'b0, 1'b0);
        rise("t1.r4", 4'b0001, 1'b1, 1'b0);
        rise("t1.r5", 4'b0010, 1'b0, 1'b0);
        Dir = 1'b1;   // takes effect on the next step
        rise("t1.dir1", 4'b0001, 1'b0, 1'b0);
        rise("t1.dir2", 4'b1000, 1'b1, 1'b0);
        Dir = 1'b0;
`endif
        expect_out("t1.end", exp_led, exp_busy, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Stop on a step edge, hold, resume, then clear.
        do_reset("t3.rst", 1'b0);
        start_run("t3.start", 4'b0001);
        rise("t3.r1", 4'b0010, 1'b0, 1'b0);
        rise("t3.r2", 4'b0100, 1'b0, 1'b0);
        rise("t3.stop", 4'b0100, 1'b0, 1'b1);
        rise("t3.hold1", 4'b0100, 1'b0, 1'b0);
        rise("t3.hold2", 4'b0100, 1'b0, 1'b0);
        expect_out("t3.resume", 4'b0100, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        rise("t3.step", 4'b1000, WRAP_TOP, 1'b0);
        expect_out("t3.stop1", 4'b1000, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        exp_led  = 4'b0000;
        exp_busy = 1'b0;
        expect_out("t3.stop2", exp_led, exp_busy, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);

        // Start+Stop together in IDLE, and tick rises in IDLE.
        expect_out("t4.both", 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        rise("t4.idle", 4'b0000, 1'b0, 1'b0);

        // Tick already high at reset release is not a rise.
        do_reset("t4.rst", 1'b1);
        start_run("t4.start", 4'b0001);
        expect_out("t4.nostep", 4'b0001, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        rise("t4.next", 4'b0010, 1'b0, 1'b0);

        // Asynchronous reset mid-run at 0010, checked before the next edge.
        #2;
        RST = 1'b1;
        #1;
        expect_out("t5.async", 4'b0000, 1'b0, 1'b0);
        drain();
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        exp_led  = 4'b0000;
        exp_busy = 1'b0;
        start_run("t5.reload", 4'b0001);

        // STEP_DIV = 3 instance, starting from MSB toward LSB.
        sel3 = 1'b1;
        do_reset("t2.rst", 1'b0);
        Dir = 1'b1;
        start_run("t2.start", 4'b1000);
        rise("t2.r1", 4'b1000, 1'b0, 1'b0);
        rise("t2.r2", 4'b1000, 1'b0, 1'b0);
        rise("t2.r3", 4'b0100, 1'b0, 1'b0);
        rise("t2.r4", 4'b0100, 1'b0, 1'b0);
        rise("t2.r5", 4'b0100, 1'b0, 1'b0);
        rise("t2.r6", 4'b0010, 1'b0, 1'b0);
        Dir = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
